// File: rtl/fan_lane_packer.sv
// Packs a row-ordered {row, data} product stream into NUM_IN-lane vectors for the
// first FAN stage, tagging every lane with {valid, complete, tail, head}.
module fan_lane_packer #(
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN  = 6,
    parameter int DW_CNT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW_DATA-1:0]        in_data,
    input  logic [DW_ROW-1:0]         in_row,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_IN*DW_LINE-1:0] out_vec,
    output logic                      busy,
    output logic [DW_CNT-1:0]         vec_cnt
);

    localparam int CW = $clog2(NUM_IN + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_IN);

    logic [DW_DATA-1:0]        lane_data [NUM_IN];
    logic [DW_ROW-1:0]         lane_row  [NUM_IN];
    logic                      lane_head [NUM_IN];
    logic                      lane_tail [NUM_IN];
    logic [CW-1:0]             cnt;
    logic [DW_ROW-1:0]         prev_row;
    logic                      first;
    logic                      flush_pend;

    logic                      out_free;
    logic                      full;
    logic                      accept;
    logic                      full_xfer;
    logic                      flush_xfer;
    logic                      head_in;
    logic                      tail_i;
    logic [CW-1:0]             last_idx;
    logic [CW-1:0]             wr_idx;
    logic [NUM_IN*DW_LINE-1:0] vec_next;

    function automatic logic [DW_LINE-1:0] make_lane(
        input logic [DW_DATA-1:0] d,
        input logic [DW_ROW-1:0]  r,
        input logic               h,
        input logic               t
    );
        return {1'b1, h & t, t, h, r, d};
    endfunction

    assign out_free   = !out_valid || out_ready;
    assign full       = (cnt == FULL);
    assign in_ready   = !flush_pend && (!full || out_free);
    assign accept     = in_valid && in_ready;
    assign full_xfer  = accept && full;
    assign flush_xfer = flush_pend && out_free;
    assign head_in    = first || (in_row != prev_row);
    assign last_idx   = cnt - CW'(1);
    assign wr_idx     = full ? '0 : cnt;
    assign busy       = (cnt != '0) || flush_pend || out_valid;

    // The newest lane's tail is only known once the next element is seen, so it is
    // resolved here from the incoming row when a full buffer is handed off.
    always_comb begin
        vec_next = '0;
        tail_i   = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (CW'(i) < cnt) begin
                tail_i = lane_tail[i];
                if (accept && (CW'(i) == last_idx))
                    tail_i = (in_row != lane_row[i]);
                vec_next[i*DW_LINE +: DW_LINE] =
                    make_lane(lane_data[i], lane_row[i], lane_head[i], tail_i);
            end
        end
    end

    // Lane buffer -> output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                lane_data[i] <= '0;
                lane_row[i]  <= '0;
                lane_head[i] <= 1'b0;
                lane_tail[i] <= 1'b0;
            end
            cnt        <= '0;
            prev_row   <= '0;
            first      <= 1'b1;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            vec_cnt    <= '0;
        end else begin
            if (out_valid && out_ready)
                vec_cnt <= vec_cnt + DW_CNT'(1);

            if (flush_xfer || full_xfer) begin
                out_vec   <= vec_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_vec   <= '0;
                out_valid <= 1'b0;
            end

            if (flush_xfer) begin
                cnt        <= '0;
                flush_pend <= 1'b0;
                first      <= 1'b1;
            end

            if (accept) begin
                prev_row <= in_row;
                first    <= 1'b0;
                if (!full && (cnt != '0))
                    lane_tail[last_idx] <= (in_row != lane_row[last_idx]);
                lane_data[wr_idx] <= in_data;
                lane_row[wr_idx]  <= in_row;
                lane_head[wr_idx] <= head_in;
                lane_tail[wr_idx] <= in_last;
                cnt <= full ? CW'(1) : cnt + CW'(1);
                if (in_last)
                    flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fan_lane_packer.sv
// Randomized and directed bench for fan_lane_packer, checked against a stream-level
// reference that derives head/tail and vector packing directly from the element list.
module tb_fan_lane_packer;

    localparam int DW_DATA = 8;
    localparam int DW_ROW  = 4;
    localparam int NUM_IN  = 6;
    localparam int DW_LINE = 16;
    localparam int VW      = NUM_IN * DW_LINE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW_DATA-1:0] in_data = '0;
    logic [DW_ROW-1:0] in_row = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [VW-1:0]     out_vec;
    logic              busy;
    logic [15:0]       vec_cnt;

    fan_lane_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_row    (in_row),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int total_vecs = 0;
    bit rnd_ready = 1'b0;

    logic [DW_ROW-1:0]  acc_row[$];
    logic [DW_DATA-1:0] acc_data[$];
    logic               acc_last[$];
    logic [VW-1:0]      got_q[$];
    logic [VW-1:0]      exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change at posedge+1, so the negedge sees exactly what the next edge will use.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_row.push_back(in_row);
            acc_data.push_back(in_data);
            acc_last.push_back(in_last);
        end
        if (rst_n && out_valid && out_ready)
            got_q.push_back(out_vec);
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [15:0] lane_of(input logic [VW-1:0] v, input int i);
        return v[i*DW_LINE +: DW_LINE];
    endfunction

    // Head/tail follow from neighbours in the accepted stream; vectors are 6-element
    // chunks counted from each stream start, cut short by a last element.
    task automatic model_build();
        logic [VW-1:0] cur;
        logic h, t;
        int s, lane;
        cur = '0;
        s = 0;
        exp_q.delete();
        for (int i = 0; i < acc_row.size(); i++) begin
            lane = (i - s) % NUM_IN;
            if (lane == 0) cur = '0;
            h = (i == s) || (acc_row[i] != acc_row[i-1]);
            t = acc_last[i] || ((i + 1 < acc_row.size()) && (acc_row[i+1] != acc_row[i]));
            cur[lane*DW_LINE +: DW_LINE] = {1'b1, h & t, t, h, acc_row[i], acc_data[i]};
            if (lane == NUM_IN - 1 || acc_last[i]) exp_q.push_back(cur);
            if (acc_last[i]) s = i + 1;
        end
    endtask

    task automatic clear_q();
        acc_row.delete();
        acc_data.delete();
        acc_last.delete();
        got_q.delete();
    endtask

    task automatic compare_phase(input string tag);
        model_build();
        chk({tag, "_nvec"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_vec%0d", tag, i), got_q[i], exp_q[i]);
        total_vecs += exp_q.size();
        chk({tag, "_vec_cnt"}, vec_cnt, 16'(total_vecs));
        clear_q();
    endtask

    // Entered and left at posedge+1; returns right after the accepting edge.
    task automatic send(input logic [DW_ROW-1:0] r, input logic [DW_DATA-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_row   = r;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            in_last = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    logic [3:0]         exp_c [6];
    logic [15:0]        ln;
    logic [VW-1:0]      snap;
    logic [DW_ROW-1:0]  r_row [60];
    logic [DW_DATA-1:0] r_data [60];
    int                 ref_sum [16];
    int                 reb_sum [16];
    int                 run;

    initial begin
        exp_c = '{4'b1001, 4'b1000, 4'b1010, 4'b1001, 4'b1010, 4'b1001};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // rows 3,3,3,5,5,7 | 7,7(last)
        send(3, 8'h10, 0); send(3, 8'h11, 0); send(3, 8'h12, 0);
        send(5, 8'h13, 0); send(5, 8'h14, 0); send(7, 8'h15, 0);
        send(7, 8'h16, 0); send(7, 8'h17, 1);
        drain();
        if (got_q.size() >= 2) begin
            for (int i = 0; i < NUM_IN; i++) begin
                ln = lane_of(got_q[0], i);
                chk($sformatf("rows_ctrl%0d", i), ln[15:12], exp_c[i]);
            end
            ln = lane_of(got_q[1], 0);
            chk("rows_v1_lane0", ln, {4'b1000, 4'd7, 8'h16});
        end
        compare_phase("rows");

        // single element with last: timing and content
        send(2, 8'h11, 1);
        @(negedge clk);
        chk("single_t1_out_valid", out_valid, 0);
        chk("single_t1_in_ready", in_ready, 0);
        @(negedge clk);
        chk("single_t2_out_valid", out_valid, 1);
        chk("single_t2_out_vec", out_vec, {80'b0, 4'b1111, 4'd2, 8'h11});
        chk("single_t2_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        drain();
        compare_phase("single");

        // rows 4,4,9(last) then a new stream on row 9
        send(4, 8'h21, 0); send(4, 8'h22, 0); send(9, 8'h23, 1);
        send(9, 8'h24, 1);
        drain();
        if (got_q.size() >= 2) begin
            ln = lane_of(got_q[0], 0); chk("r449_ctrl0", ln[15:12], 4'b1001);
            ln = lane_of(got_q[0], 1); chk("r449_ctrl1", ln[15:12], 4'b1010);
            ln = lane_of(got_q[0], 2); chk("r449_ctrl2", ln[15:12], 4'b1111);
            snap = got_q[0];
            chk("r449_unused", snap[VW-1:3*DW_LINE], 0);
            ln = lane_of(got_q[1], 0); chk("r9_new_head", ln[15:12], 4'b1111);
        end
        compare_phase("r449");

        // backpressure: output register and buffer both full
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++)
            send(4'(1 + i / 4), 8'(8'h30 + i), 0);
        in_valid = 1'b1;
        in_row = 4'd5;
        in_data = 8'h40;
        in_last = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        snap = out_vec;
        repeat (3) @(negedge clk);
        chk("bp_hold_vec", out_vec, snap);
        chk("bp_hold_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(5, 8'h40, 0);
        send(5, 8'h41, 1);
        drain();
        compare_phase("bp");

        // 60 random non-decreasing elements with random backpressure
        foreach (ref_sum[i]) begin ref_sum[i] = 0; reb_sum[i] = 0; end
        r_row[0] = 4'($urandom_range(0, 3));
        for (int i = 0; i < 60; i++) begin
            if (i > 0)
                r_row[i] = (r_row[i-1] != 4'd15 && $urandom_range(0, 3) == 0) ? r_row[i-1] + 4'd1 : r_row[i-1];
            r_data[i] = 8'($urandom);
            ref_sum[r_row[i]] += int'(r_data[i]);
        end
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++)
            send(r_row[i], r_data[i], i == 59);
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        chk("rand_nvec", got_q.size(), 10);
        run = 0;
        foreach (got_q[v]) begin
            for (int l = 0; l < NUM_IN; l++) begin
                ln = lane_of(got_q[v], l);
                if (ln[15]) begin
                    if (ln[12]) run = 0;
                    run += int'(ln[7:0]);
                    if (ln[13]) reb_sum[ln[11:8]] = run;
                end
            end
        end
        for (int r = 0; r < 16; r++)
            chk($sformatf("rand_sum_row%0d", r), reb_sum[r], ref_sum[r]);
        compare_phase("rand");

        // reset mid-vector
        send(1, 8'h51, 0); send(1, 8'h52, 0); send(2, 8'h53, 0); send(2, 8'h54, 0);
        @(negedge clk);
        chk("mid_busy_before", busy, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_vec", out_vec, 0);
        chk("mid_busy", busy, 0);
        chk("mid_vec_cnt", vec_cnt, 0);
        clear_q();
        total_vecs = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(2, 8'h5A, 1);
        drain();
        if (got_q.size() >= 1) begin
            ln = lane_of(got_q[0], 0);
            chk("mid_new_head", ln, {4'b1111, 4'd2, 8'h5A});
        end
        compare_phase("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
